// File: rtl/bk_prefix_pipe_pkg.sv
// bk_prefix_pipe shared package: (g,p) lane type, combine operator,
// default widths and derived network sizes (positions, levels, stages).
package bk_prefix_pipe_pkg;

  localparam int DEF_WIDTH       = 64;
  localparam int DEF_LVL_PER_STG = 4;
  localparam int DEF_TAG_W       = 8;

  localparam int N = DEF_WIDTH + 1;
  localparam int U = $clog2(N);
  localparam int L = 2 * U;
  localparam int S = (L + DEF_LVL_PER_STG - 1) / DEF_LVL_PER_STG;

  typedef struct packed {
    logic g;
    logic p;
  } pg_t;

  // hi covers the more significant span, lo the span just below it
  function automatic pg_t pg_combine(pg_t hi, pg_t lo);
    pg_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

endpackage

// File: rtl/bk_prefix_pipe_if.sv
// bk_prefix_pipe handshake bundle: input side (in_valid/in_ready, a, b,
// cin, tag) and output side (out_valid/out_ready, p, g, tag).
interface bk_prefix_pipe_if #(
  parameter int WIDTH = 64,
  parameter int TAG_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             cin_i;
  logic [TAG_W-1:0] tag_i;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   p_o;
  logic [WIDTH:0]   g_o;
  logic [TAG_W-1:0] tag_o;

  modport master (
    output in_valid, a_i, b_i, cin_i, tag_i, out_ready,
    input  in_ready, out_valid, p_o, g_o, tag_o
  );

  modport slave (
    input  in_valid, a_i, b_i, cin_i, tag_i, out_ready,
    output in_ready, out_valid, p_o, g_o, tag_o
  );
endinterface

// File: rtl/bk_prefix_pipe_level.sv
// bk_prefix_level: one combinational level of the Brent-Kung network.
// pg_i/pg_o: NPOS lanes of (g,p). LEVEL 0 forms (a&b, a^b) from lanes
// carrying g=a, p=b; lane 0 already holds (cin, 0) and passes through.
module bk_prefix_level
  import bk_prefix_pipe_pkg::*;
#(
  parameter int NPOS  = 65,
  parameter int NUP   = 7,
  parameter int LEVEL = 0
) (
  input  pg_t [NPOS-1:0] pg_i,
  output pg_t [NPOS-1:0] pg_o
);

  for (genvar i = 0; i < NPOS; i++) begin : g_pos
    if (LEVEL == 0) begin : g_pg
      if (i == 0) begin : g_cin
        assign pg_o[i] = pg_i[i];
      end else begin : g_ab
        assign pg_o[i] = pg_t'{g: pg_i[i].g & pg_i[i].p,
                               p: pg_i[i].g ^ pg_i[i].p};
      end
    end else if (LEVEL <= NUP) begin : g_up
      localparam int D = 1 << (LEVEL - 1);
      if (((i + 1) % (2 * D)) == 0) begin : g_op
        assign pg_o[i] = pg_combine(pg_i[i], pg_i[i-D]);
      end else begin : g_thru
        assign pg_o[i] = pg_i[i];
      end
    end else begin : g_dn
      // span halves each down-sweep level: 2^(U-j), j = LEVEL-U
      localparam int SP = 1 << (2 * NUP - LEVEL);
      localparam int H  = SP / 2;
      if ((((i + 1) % SP) == H) && (i >= SP)) begin : g_op
        assign pg_o[i] = pg_combine(pg_i[i], pg_i[i-H]);
      end else begin : g_thru
        assign pg_o[i] = pg_i[i];
      end
    end
  end

endmodule

// File: rtl/bk_prefix_pipe.sv
// bk_prefix_pipe: pipelined PG + Brent-Kung prefix for the adder.
// clk/rst (sync, active-high); bus: valid/ready in (a,b,cin,tag), out (p,g,tag).
module bk_prefix_pipe
  import bk_prefix_pipe_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int LVL_PER_STG = DEF_LVL_PER_STG,
  parameter int TAG_W       = DEF_TAG_W
) (
  input logic             clk,
  input logic             rst,
  bk_prefix_pipe_if.slave bus
);

  localparam int NP = WIDTH + 1;
  localparam int NU = $clog2(NP);
  localparam int NL = 2 * NU;
  localparam int NS = (NL + LVL_PER_STG - 1) / LVL_PER_STG;

  pg_t [NP-1:0]     raw;
  pg_t [NP-1:0]     lin  [NL];
  pg_t [NP-1:0]     lout [NL];
  logic [NP-1:0]    pv0;

  pg_t [NP-1:0]     grp_q [NS];
  logic [NP-1:0]    pv_q  [NS];
  logic [TAG_W-1:0] tag_q [NS];
  logic [NS-1:0]    vld_q;
  logic [NS-1:0]    vld_d;

  pg_t [NP-1:0]     gcap [NS];
  logic [NP-1:0]    pcap [NS];
  logic [TAG_W-1:0] tcap [NS];
  logic [NS-1:0]    src_v;
  logic [NS-1:0]    ld;
  logic [NS-1:0]    en;
  logic [NP-1:0]    gout;

  always_comb begin
    raw[0] = pg_t'{g: bus.cin_i, p: 1'b0};
    for (int i = 1; i < NP; i++) begin
      raw[i] = pg_t'{g: bus.a_i[i-1], p: bus.b_i[i-1]};
    end
    for (int i = 0; i < NP; i++) begin
      pv0[i]  = lout[0][i].p;
      gout[i] = grp_q[NS-1][i].g;
    end
  end

  // a level that starts a stage reads that stage's predecessor register
  for (genvar l = 0; l < NL; l++) begin : g_lvl
    if (l == 0) begin : g_src_in
      assign lin[l] = raw;
    end else if ((l % LVL_PER_STG) == 0) begin : g_src_reg
      assign lin[l] = grp_q[l/LVL_PER_STG-1];
    end else begin : g_src_chain
      assign lin[l] = lout[l-1];
    end
    bk_prefix_level #(
      .NPOS  (NP),
      .NUP   (NU),
      .LEVEL (l)
    ) u_lvl (
      .pg_i (lin[l]),
      .pg_o (lout[l])
    );
  end

  for (genvar k = 0; k < NS; k++) begin : g_stg
    localparam int END  = (k + 1) * LVL_PER_STG;
    localparam int LAST = ((END < NL) ? END : NL) - 1;
    assign gcap[k] = lout[LAST];
    if (k == 0) begin : g_first
      assign pcap[k]  = pv0;
      assign tcap[k]  = bus.tag_i;
      assign src_v[k] = bus.in_valid;
    end else begin : g_next
      assign pcap[k]  = pv_q[k-1];
      assign tcap[k]  = tag_q[k-1];
      assign src_v[k] = vld_q[k-1];
    end
  end

  // a stage may load when empty or when its successor loads
  always_comb begin
    logic nxt;
    nxt = bus.out_ready;
    for (int k = NS - 1; k >= 0; k--) begin
      nxt   = !vld_q[k] || nxt;
      ld[k] = nxt;
    end
    for (int k = 0; k < NS; k++) begin
      vld_d[k] = ld[k] ? src_v[k] : vld_q[k];
      en[k]    = ld[k] && src_v[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int k = 0; k < NS; k++) begin
        grp_q[k] <= '0;
        pv_q[k]  <= '0;
        tag_q[k] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      for (int k = 0; k < NS; k++) begin
        if (en[k]) begin
          grp_q[k] <= gcap[k];
          pv_q[k]  <= pcap[k];
          tag_q[k] <= tcap[k];
        end
      end
    end
  end

  assign bus.in_ready  = ld[0];
  assign bus.out_valid = vld_q[NS-1];
  assign bus.g_o       = gout;
  assign bus.p_o       = pv_q[NS-1];
  assign bus.tag_o     = tag_q[NS-1];

endmodule

// File: tb/tb_bk_prefix_pipe.sv
// tb_bk_prefix_pipe: directed vectors for the prefix pipe, checking
// carries, propagates, sums, tags, latency and handshake behaviour.
module tb_bk_prefix_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bk_prefix_pipe_if #(.WIDTH(64), .TAG_W(8)) bus ();

  bk_prefix_pipe #(
    .WIDTH       (64),
    .LVL_PER_STG (4),
    .TAG_W       (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic [7:0]  tag;
    int          t;
  } op_t;

  op_t pend[$];
  op_t expq[$];

  int nvec = 0;
  int nerr = 0;
  int edges = 0;
  int nout = 0;
  int nacc = 0;
  int last_lat = 0;
  logic [64:0] last_g;
  logic [64:0] last_p;
  logic [63:0] last_s;

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // carry into bit i, computed by plain addition of the low i bits
  function automatic logic [64:0] carries(logic [63:0] a, logic [63:0] b,
                                          logic cin);
    logic [64:0] c;
    logic [64:0] m;
    logic [64:0] t;
    c[0] = cin;
    for (int i = 1; i <= 64; i++) begin
      m = (65'd1 << i) - 65'd1;
      t = ({1'b0, a} & m) + ({1'b0, b} & m) + {64'd0, cin};
      c[i] = t[i];
    end
    return c;
  endfunction

  task automatic push(input logic [63:0] a, input logic [63:0] b,
                      input logic cin, input logic [7:0] tag);
    op_t o;
    o.a = a; o.b = b; o.cin = cin; o.tag = tag; o.t = 0;
    pend.push_back(o);
  endtask

  task automatic step();
    op_t o;
    logic [64:0] sum;
    if (pend.size() > 0) begin
      bus.a_i = pend[0].a;
      bus.b_i = pend[0].b;
      bus.cin_i = pend[0].cin;
      bus.tag_i = pend[0].tag;
      bus.in_valid = 1'b1;
    end else begin
      bus.in_valid = 1'b0;
    end
    @(negedge clk);
    if (bus.out_valid && bus.out_ready) begin
      check("out_expected", {127'd0, expq.size() != 0}, 128'd1);
      if (expq.size() != 0) begin
        o = expq.pop_front();
        nout++;
        last_g = bus.g_o;
        last_p = bus.p_o;
        last_s = bus.g_o[63:0] ^ bus.p_o[64:1];
        last_lat = edges - o.t;
        sum = {1'b0, o.a} + {1'b0, o.b} + {64'd0, o.cin};
        check("g", {63'd0, bus.g_o}, {63'd0, carries(o.a, o.b, o.cin)});
        check("p", {63'd0, bus.p_o}, {63'd0, o.a ^ o.b, 1'b0});
        check("sum", {63'd0, bus.g_o[64], last_s}, {63'd0, sum});
        check("tag", {120'd0, bus.tag_o}, {120'd0, o.tag});
      end
    end
    if (bus.in_valid && bus.in_ready) begin
      o = pend.pop_front();
      o.t = edges;
      expq.push_back(o);
      nacc++;
    end
    @(posedge clk);
    edges++;
    #1;
  endtask

  task automatic wait_out(input int target);
    int n;
    n = 0;
    while (nout < target && n < 40) begin
      step();
      n++;
    end
    check("wait_out", nout, target);
  endtask

  int base_acc;
  int base_out;
  int steps;

  initial begin
    bus.in_valid = 1'b0;
    bus.a_i = '0;
    bus.b_i = '0;
    bus.cin_i = 1'b0;
    bus.tag_i = '0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_out_valid", {127'd0, bus.out_valid}, 128'd0);
    check("rst_g", {63'd0, bus.g_o}, 128'd0);
    check("rst_p", {63'd0, bus.p_o}, 128'd0);
    check("rst_tag", {120'd0, bus.tag_o}, 128'd0);
    check("rst_in_ready", {127'd0, bus.in_ready}, 128'd1);

    // all-ones carry chain
    bus.out_ready = 1'b1;
    push(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 8'hA1);
    wait_out(nout + 1);
    check("t1_lat", last_lat, 4);
    check("t1_g", {63'd0, last_g}, {63'd0, 65'h1_FFFF_FFFF_FFFF_FFFF});
    check("t1_p", {63'd0, last_p}, {63'd0, 65'h1_FFFF_FFFF_FFFF_FFFE});
    check("t1_sum", {63'd0, last_g[64], last_s}, {63'd0, 65'h1_0000_0000_0000_0000});

    // +1 on ...EF ripples through the low nibble: carries into bits 1..4
    push(64'h0123_4567_89AB_CDEF, 64'h1, 1'b0, 8'hB2);
    wait_out(nout + 1);
    check("t2_lat", last_lat, 4);
    check("t2_g", {63'd0, last_g}, {63'd0, 65'h0_0000_0000_0000_001E});
    check("t2_p", {63'd0, last_p}, {63'd0, 65'h0_0246_8ACF_1357_9BDC});
    check("t2_sum", {63'd0, last_g[64], last_s}, {63'd0, 65'h0_0123_4567_89AB_CDF0});

    // back-to-back streaming
    base_out = nout;
    for (int i = 0; i < 1000; i++) begin
      push({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom),
           8'($urandom));
    end
    steps = 0;
    while (nout < base_out + 1000 && steps < 3000) begin
      check("t3_in_ready", {127'd0, bus.in_ready}, 128'd1);
      step();
      steps++;
    end
    check("t3_cycles", steps, 1004);

    // backpressure: six offered, four absorbed
    bus.out_ready = 1'b0;
    base_acc = nacc;
    base_out = nout;
    for (int i = 0; i < 6; i++) begin
      push({$urandom, $urandom}, {$urandom, $urandom}, 1'(i), 8'(8'h40 + i));
    end
    repeat (8) step();
    check("t4_accepted", nacc - base_acc, 4);
    check("t4_in_ready", {127'd0, bus.in_ready}, 128'd0);
    check("t4_no_out", nout - base_out, 0);
    repeat (3) begin
      check("t4_out_valid", {127'd0, bus.out_valid}, 128'd1);
      if (expq.size() > 0) begin
        check("t4_hold_tag", {120'd0, bus.tag_o}, {120'd0, expq[0].tag});
        check("t4_hold_g", {63'd0, bus.g_o},
              {63'd0, carries(expq[0].a, expq[0].b, expq[0].cin)});
      end
      step();
    end
    bus.out_ready = 1'b1;
    #1;
    check("t4_ready_comb", {127'd0, bus.in_ready}, 128'd1);
    wait_out(base_out + 6);
    check("t4_all_in", nacc - base_acc, 6);

    // simultaneous in/out on a full pipe
    bus.out_ready = 1'b0;
    base_acc = nacc;
    base_out = nout;
    for (int i = 0; i < 4; i++) begin
      push({$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 8'(8'h50 + i));
    end
    repeat (6) step();
    check("t5_fill", nacc - base_acc, 4);
    push(64'h1234, 64'h5678, 1'b0, 8'h55);
    bus.out_ready = 1'b1;
    #1;
    check("t5_in_ready", {127'd0, bus.in_ready}, 128'd1);
    step();
    check("t5_one_out", nout - base_out, 1);
    check("t5_one_in", nacc - base_acc, 5);
    bus.out_ready = 1'b0;
    #1;
    check("t5_still_full", {127'd0, bus.in_ready}, 128'd0);
    check("t5_out_valid", {127'd0, bus.out_valid}, 128'd1);
    bus.out_ready = 1'b1;
    wait_out(base_out + 5);

    // reset with three in flight
    base_acc = nacc;
    for (int i = 0; i < 3; i++) begin
      push({$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 8'(8'h60 + i));
    end
    repeat (3) step();
    check("t6_in_flight", nacc - base_acc, 3);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    edges++;
    #1 rst = 1'b0;
    expq.delete();
    check("t6_out_valid", {127'd0, bus.out_valid}, 128'd0);
    check("t6_g", {63'd0, bus.g_o}, 128'd0);
    check("t6_in_ready", {127'd0, bus.in_ready}, 128'd1);
    bus.out_ready = 1'b1;
    base_out = nout;
    repeat (10) begin
      check("t6_quiet", {127'd0, bus.out_valid}, 128'd0);
      step();
    end
    check("t6_none", nout - base_out, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
